rr_mux_4_1: RTL and testbench
=============================

# rr_mux_4_1

Registered four-source round-robin stream multiplexer. Sits directly upstream of the 4:1 data mux stage: it arbitrates among four valid/ready sources, captures the winning word into a one-entry output register, and publishes the 2-bit source index alongside it. Downstream logic can therefore reuse the index as a mux select or as a tag. It turns the purely combinational select into a fair, backpressure-aware, pipelined stage.

## Interface
- WIDTH, 4, data word width of every source and of the output
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  4  bit i: source i presents a word
- in_data0, in_data1, in_data2, in_data3  input  WIDTH each  source words
- in_ready  output  4  bit i: source i's word is accepted this cycle (one-hot or zero)
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered word
- out_src  output  2  index (0..3) of the source that produced out_data
- out_ready  input  1  downstream accepts out_data this cycle

## Operation
- State:
  - output register {out_valid, out_data, out_src}
  - round-robin pointer last_grant[1:0]
- free = !out_valid || out_ready; the register can load this cycle.
- Grant search, combinational:
  - Scan sources in order last_grant+1, +2, +3, +4 (mod 4).
  - grant = first index with in_valid set; any = |in_valid.
- in_ready[i] = free && any && (grant == i). At most one bit is set. in_ready depends combinationally on out_ready and in_valid.
- On a clock edge, when free && any:
  - out_data <= in_data[grant]
  - out_src <= grant
  - out_valid <= 1
  - last_grant <= grant
- On a clock edge, when free && !any:
  - out_valid <= 0
  - out_data and out_src hold their values
  - last_grant unchanged
- On a clock edge, when !free: all state holds. out_data and out_src stay stable while out_valid && !out_ready.
- Fairness:
  - A continuously requesting source waits at most 3 accepted transfers before it is granted.
  - A lone requester is granted every cycle the register is free.
- Width rule: out_src is 2 bits. Index arithmetic wraps modulo 4 (3+1 = 0).
- Sources must hold in_valid and data until in_ready. The block does not rely on this; a word withdrawn before in_ready is simply not seen.

## Timing
- Reset, synchronous to clk and dominant over all other activity:
  - out_valid = 0, out_data = 0, out_src = 0
  - last_grant = 3, so source 0 has first priority
- During and immediately after reset, in_ready = 0 for the cycle rst is high.
- Reset asserted mid-transfer discards any held word. No handshake completes in a cycle where rst = 1.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N (one cycle).
- Throughput: one word per cycle when out_ready is held high.
- Same-cycle pop and push: when out_valid && out_ready and a source is valid, the old word leaves and the new word loads on the same edge with no bubble.
- Backpressure: when out_ready = 0 with out_valid = 1, in_ready = 0 and the pointer freezes.
- Empty: with in_valid = 0, out_valid drops one cycle after the last word is consumed.

## Test plan
- Reset, then in_valid = 4'b1111 with data 0xA, 0xB, 0xC, 0xD and out_ready = 1 held → out_src sequence 0,1,2,3,0,… and out_data A,B,C,D,A…; in_ready one-hot, rotating 0001, 0010, 0100, 1000.
- Only source 2 valid (data 0x5) for 4 cycles, out_ready = 1 → in_ready = 0100 every cycle; out_data = 5 and out_src = 2 from the cycle after the first accept.
- Backpressure: load a word from source 1 (0x7), then hold out_ready = 0 for 3 cycles with all sources valid → out_data stays 7, out_src stays 1, in_ready = 0000; the first cycle out_ready = 1 accepts source 2.
- Fairness under contention: sources 0 and 3 valid continuously, last_grant = 3 → grants alternate 0,3,0,3.
- Reset mid-stream: out_valid = 1 with out_data = 0xC, rst pulsed for one cycle → next cycle out_valid = 0, out_data = 0, out_src = 0, in_ready = 0 during rst; the first grant afterwards goes to the lowest valid index.
- Drain: all in_valid drop while out_valid = 1 and out_ready = 1 → out_valid = 0 on the next cycle, and out_data retains its last value.

Source files
------------

// File: rtl/rr_mux_4_1.sv
// Four-source round-robin stream multiplexer with a one-entry registered output.
// The winning source index travels with the word on out_src.
module rr_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  // Handshake: a word moves on a rising edge when valid && ready are both high
  // in that cycle; in_ready never depends on the source's own data, only on
  // in_valid, the register occupancy and out_ready.

  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic             any;
  logic             free;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  assign any  = |in_valid;
  assign free = !out_valid || out_ready;
  assign load = free && any && !rst;

  // Scan last_grant+1 .. last_grant+4; the 2-bit add wraps modulo 4.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    grant = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!found && in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = in_data0;
    case (grant)
      2'd0: grant_data = in_data0;
      2'd1: grant_data = in_data1;
      2'd2: grant_data = in_data2;
      2'd3: grant_data = in_data3;
      default: grant_data = in_data0;
    endcase
  end

  assign in_ready = load ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= 2'd3;
    end else if (free) begin
      if (any) begin
        out_valid  <= 1'b1;
        out_data   <= grant_data;
        out_src    <= grant;
        last_grant <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Bench for rr_mux_4_1: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model and an expected-word queue.
module tb_rr_mux_4_1;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux_4_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  bit           model_ok = 0;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;
  logic [W-1:0] exp_q[$];

  function automatic int model_grant();
    for (int k = 1; k <= 4; k++) begin
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] word_of(input int i);
    case (i)
      0: return in_data0;
      1: return in_data1;
      2: return in_data2;
      default: return in_data3;
    endcase
  endfunction

  always @(posedge clk) begin
    int  g;
    bit  fr;
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 3;
      exp_q.delete();
      model_ok = 1;
    end else if (model_ok) begin
      g  = model_grant();
      fr = !m_valid || out_ready;
      if (fr && m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fr) begin
        if (g >= 0) begin
          m_data = word_of(g); m_src = g; m_valid = 1; m_ptr = g;
          exp_q.push_back(word_of(g));
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int   g;
    logic [3:0] er;
    if (model_ok) begin
      g  = model_grant();
      er = 4'b0000;
      if (!rst && (!m_valid || out_ready) && g >= 0) er = 4'b0001 << g;
      check("model in_ready", int'(in_ready), int'(er));
      check("model out_valid", int'(out_valid), int'(m_valid));
      check("model out_data", int'(out_data), int'(m_data));
      check("model out_src", int'(out_src), m_src);
      if (m_valid && out_ready && !rst) begin
        check("scoreboard depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("scoreboard word", int'(out_data), int'(exp_q[0]));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, d1, d2, d3);
    in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
    set_data(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    in_valid = 4'b1111;
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset out_src", int'(out_src), 0);
    tick();

    // rotation with all sources valid
    rst = 1'b0; out_ready = 1'b1;
    set_data(4'hA, 4'hB, 4'hC, 4'hD);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rotate in_ready", int'(in_ready), 1 << (i % 4));
      if (i > 0) begin
        check("rotate out_src", int'(out_src), (i - 1) % 4);
        check("rotate out_data", int'(out_data), 'hA + (i - 1) % 4);
      end
      tick();
    end

    // lone requester
    in_valid = 4'b0100; in_data2 = 4'h5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lone in_ready", int'(in_ready), 'b0100);
      if (i > 0) begin
        check("lone out_data", int'(out_data), 5);
        check("lone out_src", int'(out_src), 2);
      end
      tick();
    end

    // backpressure
    in_valid = 4'b0010; in_data1 = 4'h7;
    @(negedge clk);
    check("bp load in_ready", int'(in_ready), 'b0010);
    tick();
    out_ready = 1'b0; in_valid = 4'b1111;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp in_ready", int'(in_ready), 0);
      check("bp out_valid", int'(out_valid), 1);
      check("bp out_data", int'(out_data), 7);
      check("bp out_src", int'(out_src), 1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", int'(in_ready), 'b0100);
    tick();

    // reset mid-stream
    in_valid = 4'b0100; in_data2 = 4'hC;
    @(negedge clk);
    check("pre-reset in_ready", int'(in_ready), 'b0100);
    tick();
    rst = 1'b1; in_valid = 4'b1001;
    set_data(4'h1, 4'h2, 4'h3, 4'h9);
    @(negedge clk);
    check("mid rst in_ready", int'(in_ready), 0);
    check("mid rst held word", int'(out_data), 'hC);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post rst out_valid", int'(out_valid), 0);
    check("post rst out_data", int'(out_data), 0);
    check("post rst out_src", int'(out_src), 0);

    // fairness between sources 0 and 3
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("fair in_ready", int'(in_ready), (i % 2 == 0) ? 'b0001 : 'b1000);
      tick();
    end

    // drain
    in_valid = 4'b0000;
    @(negedge clk);
    check("drain in_ready", int'(in_ready), 0);
    check("drain last src", int'(out_src), 3);
    tick();
    @(negedge clk);
    check("drain out_valid", int'(out_valid), 0);
    check("drain out_data", int'(out_data), 9);
    check("drain out_src", int'(out_src), 3);
    tick();

    // mixed traffic, checked by the model only
    for (int i = 0; i < 300; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      set_data(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
